key_event_decoder: RTL



---
 rtl/key_event_decoder.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/key_event_decoder.sv
// Turns a debounced key level into one-cycle click / double-click / long-press events.
// Macro KEY_EVT_DOUBLE_EN builds the double-click path (WAIT_GAP, PRESS2); without it a release emits click at once.
module key_event_decoder #(
  parameter bit ACTIVE_LOW  = 1'b1,
  parameter int LONG_CYCLES = 50_000_000,
  parameter int DOUBLE_GAP  = 12_500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clean_key,
  output logic key_pressed,
  output logic click,
  output logic double_click,
  output logic long_press,
  output logic busy
);

  // state      | meaning
  // IDLE       | no key activity, waiting for a press
  // PRESS1     | first press held, timing toward long press
  // WAIT_GAP   | first press released, timing the double-click window
  // PRESS2     | second press held, timing toward long press
  // LONG_HELD  | long press reported, waiting for release

  localparam int MAXC = (LONG_CYCLES > DOUBLE_GAP) ? LONG_CYCLES : DOUBLE_GAP;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] LONG_TC = CW'(LONG_CYCLES - 1);
`ifdef KEY_EVT_DOUBLE_EN
  localparam logic [CW-1:0] GAP_TC  = CW'(DOUBLE_GAP - 1);
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS1,
`ifdef KEY_EVT_DOUBLE_EN
    ST_WAIT_GAP,
    ST_PRESS2,
`endif
    ST_LONG_HELD
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          key_pressed_q;
  logic          click_q;
  logic          dbl_q;
  logic          long_q;
  logic          busy_q;
  logic          p;

  assign p = (clean_key == !ACTIVE_LOW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      key_pressed_q <= 1'b0;
      click_q       <= 1'b0;
      dbl_q         <= 1'b0;
      long_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      key_pressed_q <= p;
      click_q       <= 1'b0;
      dbl_q         <= 1'b0;
      long_q        <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (p) begin
            state_q <= ST_PRESS1;
            busy_q  <= 1'b1;
          end
        end
        ST_PRESS1: begin
          // a release on the threshold edge still counts as a short press
          if (!p) begin
            cnt_q <= '0;
`ifdef KEY_EVT_DOUBLE_EN
            state_q <= ST_WAIT_GAP;
`else
            click_q <= 1'b1;
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
`endif
          end else if (cnt_q == LONG_TC) begin
            long_q  <= 1'b1;
            state_q <= ST_LONG_HELD;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
`ifdef KEY_EVT_DOUBLE_EN
        ST_WAIT_GAP: begin
          if (p) begin
            state_q <= ST_PRESS2;
            cnt_q   <= '0;
          end else if (cnt_q == GAP_TC) begin
            click_q <= 1'b1;
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_PRESS2: begin
          // a second press held long enough swallows the pending click
          if (!p) begin
            dbl_q   <= 1'b1;
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (cnt_q == LONG_TC) begin
            long_q  <= 1'b1;
            state_q <= ST_LONG_HELD;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
`endif
        ST_LONG_HELD: begin
          cnt_q <= '0;
          if (!p) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign key_pressed  = key_pressed_q;
  assign click        = click_q;
  assign double_click = dbl_q;
  assign long_press   = long_q;
  assign busy         = busy_q;

endmodule
